// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU execute stage.
package alu_pkg;

    // Bit positions of the flags inside a packed NZCV nibble
    localparam int unsigned NZCV_N = 3;
    localparam int unsigned NZCV_Z = 2;
    localparam int unsigned NZCV_C = 1;
    localparam int unsigned NZCV_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    // Occupancy of one register slice
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

    // Unpack a raw ALU flag nibble into named fields
    function automatic nzcv_t to_nzcv(input logic [3:0] flags);
        nzcv_t f;
        f.n = flags[NZCV_N];
        f.z = flags[NZCV_Z];
        f.c = flags[NZCV_C];
        f.v = flags[NZCV_V];
        return f;
    endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Bus bundle of the ALU execute stage: upstream handshake, ALU side
// connection, downstream handshake and the status register.
interface alu_exec_stage_if #(
    parameter int unsigned N = 8
);
    // upstream
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [1:0]   in_op;
    logic         in_set_flags;
    // ALU beside the stage
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [1:0]   alu_ctrl;
    logic [N-1:0] alu_out;
    logic [3:0]   alu_nzcv;
    // downstream
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_result;
    logic [3:0]   out_nzcv;
    // status
    logic [3:0]   status_nzcv;
    logic         status_clr;

    // The execute stage itself
    modport slave (
        input  in_valid, in_a, in_b, in_op, in_set_flags,
        input  alu_out, alu_nzcv,
        input  out_ready, status_clr,
        output in_ready, alu_a, alu_b, alu_ctrl,
        output out_valid, out_result, out_nzcv, status_nzcv
    );

    // Surrounding logic (producer, ALU, consumer)
    modport master (
        output in_valid, in_a, in_b, in_op, in_set_flags,
        output alu_out, alu_nzcv,
        output out_ready, status_clr,
        input  in_ready, alu_a, alu_b, alu_ctrl,
        input  out_valid, out_result, out_nzcv, status_nzcv
    );

endinterface

// File: rtl/pipe_reg_stage.sv
// Generic valid/ready register slice holding one W-bit payload.
// Accepts whenever empty or when the held word leaves in the same cycle.
module pipe_reg_stage
    import alu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    stage_state_t r_state;
    stage_state_t w_state_nxt;
    logic [W-1:0] r_data;
    logic         w_load;
    logic         w_drain;

    assign o_ready = (r_state == ST_EMPTY) || i_ready;
    assign w_load  = i_valid && o_ready;
    assign w_drain = (r_state == ST_FULL) && i_ready;
    assign o_valid = (r_state == ST_FULL);
    assign o_data  = r_data;

    // Occupancy register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Occupancy transitions: a drain with a simultaneous load stays full
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_load) w_state_nxt = ST_FULL;
            ST_FULL:  if (w_drain && !w_load) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Payload loads only on accept, otherwise holds (also while empty)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (w_load) begin
            r_data <= i_data;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage around an external ALU: operand slice (S1)
// feeds the ALU, result slice (S2) captures its output, and a persistent
// NZCV status register is updated by flag-setting operations.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic               clk,
    input  logic               reset,
    alu_exec_stage_if.slave    bus
);

    localparam int unsigned W_S1 = 2 * N + 3;
    localparam int unsigned W_S2 = N + 4;

    logic [W_S1-1:0] w_s1_in;
    logic [W_S1-1:0] w_s1_q;
    logic            w_s1_valid;
    logic            w_in_ready;

    logic [W_S2-1:0] w_s2_in;
    logic [W_S2-1:0] w_s2_q;
    logic            w_s2_valid;
    logic            w_s2_ready_up;

    logic [N-1:0]    w_s1_a;
    logic [N-1:0]    w_s1_b;
    logic [1:0]      w_s1_op;
    logic            w_s1_set_flags;
    logic            w_s1_adv;

    nzcv_t           r_status;

    assign w_s1_in = {bus.in_a, bus.in_b, bus.in_op, bus.in_set_flags};
    assign {w_s1_a, w_s1_b, w_s1_op, w_s1_set_flags} = w_s1_q;

    // set_flags takes effect as the op leaves S1, so S2 carries only
    // the result and its flags.
    assign w_s2_in = {bus.alu_out, bus.alu_nzcv};

    // S2 is ready for S1 when empty or being consumed: this is s1_adv's gate
    assign w_s1_adv = w_s1_valid && w_s2_ready_up;

    pipe_reg_stage #(
        .W (W_S1)
    ) u_s1 (
        .clk     (clk),
        .reset   (reset),
        .i_valid (bus.in_valid),
        .o_ready (w_in_ready),
        .i_data  (w_s1_in),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready_up),
        .o_data  (w_s1_q)
    );

    pipe_reg_stage #(
        .W (W_S2)
    ) u_s2 (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready_up),
        .i_data  (w_s2_in),
        .o_valid (w_s2_valid),
        .i_ready (bus.out_ready),
        .o_data  (w_s2_q)
    );

    // Status register: clear has priority over a flag-setting retire
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_status <= '0;
        end else if (bus.status_clr) begin
            r_status <= '0;
        end else if (w_s1_adv && w_s1_set_flags) begin
            r_status <= to_nzcv(bus.alu_nzcv);
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.alu_a       = w_s1_a;
    assign bus.alu_b       = w_s1_b;
    assign bus.alu_ctrl    = w_s1_op;
    assign bus.out_valid   = w_s2_valid;
    assign bus.out_result  = w_s2_q[W_S2-1:4];
    assign bus.out_nzcv    = w_s2_q[3:0];
    assign bus.status_nzcv = r_status;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: an ALU model sits beside the stage, and a
// queue-based occupancy model predicts every output each cycle.
module tb_alu_exec_stage;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   dut_fires = 0;

    alu_exec_stage_if #(.N(8)) bus ();

    alu_exec_stage #(.N(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU: 0 add, 1 sub (carry = no borrow), 2 and, 3 or; returns {result, nzcv}
    function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        logic       v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            2'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0]; c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            2'd1: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[7:0]; c = ~s[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            2'd2: r = a & b;
            default: r = a | b;
        endcase
        return {r, r[7], (r == 8'h00), c, v};
    endfunction

    assign {bus.alu_out, bus.alu_nzcv} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_ctrl);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic       sf;
    } op_t;

    op_t        mq[$];             // ops held by the stage, oldest first (at most 2)
    bit         m_head_out = 0;    // oldest op already sits in the result register
    logic [7:0] m_res    = '0;
    logic [3:0] m_nzcv   = '0;
    logic [3:0] m_status = '0;
    op_t        m_last   = '0;     // last accepted op, visible on the ALU port

    initial forever begin
        bit          can_take;
        op_t         nop;
        logic [11:0] r;
        @(posedge clk or posedge reset);
        if (reset) begin
            mq.delete();
            m_head_out = 0;
            m_res = '0; m_nzcv = '0; m_status = '0; m_last = '0;
        end else begin
            can_take = !(mq.size() == 2 && !bus.out_ready);
            nop.a = bus.in_a; nop.b = bus.in_b; nop.op = bus.in_op; nop.sf = bus.in_set_flags;
            if (m_head_out && bus.out_ready) begin
                void'(mq.pop_front());
                m_head_out = 0;
            end
            if (mq.size() > 0 && !m_head_out) begin
                m_head_out = 1;
                r = alu_fn(mq[0].a, mq[0].b, mq[0].op);
                m_res  = r[11:4];
                m_nzcv = r[3:0];
                if (mq[0].sf) m_status = r[3:0];
            end
            if (bus.status_clr) m_status = '0;
            if (bus.in_valid && can_take) begin
                mq.push_back(nop);
                m_last = nop;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("in_ready",    {31'd0, bus.in_ready},  {31'd0, !(mq.size() == 2 && !bus.out_ready)});
        chk("out_valid",   {31'd0, bus.out_valid}, {31'd0, m_head_out});
        chk("out_result",  {24'd0, bus.out_result}, {24'd0, m_res});
        chk("out_nzcv",    {28'd0, bus.out_nzcv},   {28'd0, m_nzcv});
        chk("status_nzcv", {28'd0, bus.status_nzcv}, {28'd0, m_status});
        chk("alu_a",       {24'd0, bus.alu_a},    {24'd0, m_last.a});
        chk("alu_b",       {24'd0, bus.alu_b},    {24'd0, m_last.b});
        chk("alu_ctrl",    {30'd0, bus.alu_ctrl}, {30'd0, m_last.op});
        if (bus.out_valid && bus.out_ready) dut_fires++;
    end

    // ---------------- stimulus ----------------
    task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input logic sf);
        bus.in_valid = 1'b1;
        bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_set_flags = sf;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int d0;

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0;
        bus.in_set_flags = 1'b0; bus.out_ready = 1'b1; bus.status_clr = 1'b0;

        // Literal pins on the ALU model
        chk("pin_add_05_03", {20'd0, alu_fn(8'h05, 8'h03, 2'd0)}, {20'd0, 8'h08, 4'b0000});
        chk("pin_and_0f_f0", {20'd0, alu_fn(8'h0F, 8'hF0, 2'd2)}, {20'd0, 8'h00, 4'b0100});
        chk("pin_add_40_40", {20'd0, alu_fn(8'h40, 8'h40, 2'd0)}, {20'd0, 8'h80, 4'b1001});
        chk("pin_add_f0_90", {20'd0, alu_fn(8'hF0, 8'h90, 2'd0)}, {20'd0, 8'h80, 4'b1010});
        chk("pin_sub_05_07", {20'd0, alu_fn(8'h05, 8'h07, 2'd1)}, {20'd0, 8'hFE, 4'b1000});

        step(); step();
        reset = 1'b0;
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_result", {24'd0, bus.out_result}, 32'd0);
        chk("rst_status",    {28'd0, bus.status_nzcv}, 32'd0);
        chk("rst_alu_a",     {24'd0, bus.alu_a}, 32'd0);

        // Single op, two-edge latency
        offer(8'h05, 8'h03, 2'd0, 1'b1);
        chk("t1_ready", {31'd0, bus.in_ready}, 32'd1);
        step();                                   // E0: accepted
        bus.in_valid = 1'b0;
        chk("t1_not_yet", {31'd0, bus.out_valid}, 32'd0);
        step();                                   // E1: in result register
        chk("t1_valid",  {31'd0, bus.out_valid}, 32'd1);
        chk("t1_result", {24'd0, bus.out_result}, 32'h08);
        chk("t1_status", {28'd0, bus.status_nzcv}, 32'd0);
        step();                                   // consumed

        // Back-to-back stream of 16
        d0 = dut_fires;
        for (int i = 0; i < 16; i++) begin
            offer(8'(i * 7), 8'(i * 3 + 1), 2'(i % 4), 1'(i % 2));
            @(negedge clk);
            chk("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (3) step();
        chk("stream_count", dut_fires - d0, 32'd16);

        // Full stall: third op must wait
        d0 = dut_fires;
        bus.out_ready = 1'b0;
        offer(8'h10, 8'h20, 2'd0, 1'b0); step();
        offer(8'h05, 8'h07, 2'd1, 1'b0); step();
        offer(8'h0C, 8'h30, 2'd3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("stall_hold",     {24'd0, bus.out_result}, 32'h30);
        end
        step();
        bus.out_ready = 1'b1;
        step();                                   // third op accepted here
        bus.in_valid = 1'b0;
        repeat (4) step();
        chk("stall_count", dut_fires - d0, 32'd3);

        // Flag masking
        offer(8'h0F, 8'hF0, 2'd2, 1'b1); step();
        offer(8'h40, 8'h40, 2'd0, 1'b0); step();
        bus.in_valid = 1'b0;
        step();
        chk("mask_out_nzcv", {28'd0, bus.out_nzcv}, 32'b1001);
        chk("mask_result",   {24'd0, bus.out_result}, 32'h80);
        chk("mask_status",   {28'd0, bus.status_nzcv}, 32'b0100);

        // Clear wins over a same-edge flag update
        offer(8'hF0, 8'h90, 2'd0, 1'b1); step();
        bus.in_valid = 1'b0;
        bus.status_clr = 1'b1;
        step();
        bus.status_clr = 1'b0;
        chk("clr_status",   {28'd0, bus.status_nzcv}, 32'd0);
        chk("clr_out_nzcv", {28'd0, bus.out_nzcv}, 32'b1010);
        step();

        // Reset with both stages full
        bus.out_ready = 1'b0;
        offer(8'h40, 8'h40, 2'd0, 1'b1); step();
        offer(8'h01, 8'h02, 2'd3, 1'b0); step();
        bus.in_valid = 1'b0;
        chk("pre_rst_valid",  {31'd0, bus.out_valid}, 32'd1);
        chk("pre_rst_status", {28'd0, bus.status_nzcv}, 32'b1001);
        chk("pre_rst_ready",  {31'd0, bus.in_ready}, 32'd0);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_valid",  {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_status", {28'd0, bus.status_nzcv}, 32'd0);
        chk("mid_rst_ready",  {31'd0, bus.in_ready}, 32'd1);
        step();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        offer(8'hF0, 8'h90, 2'd0, 1'b1);
        step();
        bus.in_valid = 1'b0;
        step();
        chk("post_rst_valid",  {31'd0, bus.out_valid}, 32'd1);
        chk("post_rst_result", {24'd0, bus.out_result}, 32'h80);
        chk("post_rst_status", {28'd0, bus.status_nzcv}, 32'b1010);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage wrapped around the combinational `arithmetic_logic_unit`. It accepts operations over a valid/ready handshake and drives the ALU from an operand register. It captures the ALU result and flags into an output register, and keeps a persistent NZCV status register for condition evaluation by downstream control. Throughput is one operation per cycle; backpressure is supported without data loss.

## Interface
- `N`, default 8: operand and result width, passed to the ALU.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `in_valid`  in  1: upstream offers an operation.
- `in_ready`  out  1: stage can accept this cycle.
- `in_a`, `in_b`  in  N: operands.
- `in_op`  in  2: ALU control code, passed through unchanged.
- `in_set_flags`  in  1: update the status register when this operation retires.
- `alu_a`, `alu_b`  out  N: driven from the operand register to the ALU.
- `alu_ctrl`  out  2: driven from the operand register to the ALU.
- `alu_out`  in  N: ALU result.
- `alu_nzcv`  in  4: ALU flags {negative, zero, carry_out, overflow}.
- `out_valid`  out  1: result register holds a result.
- `out_ready`  in  1: downstream consumes this cycle.
- `out_result`  out  N: registered result.
- `out_nzcv`  out  4: registered flags of this result.
- `status_nzcv`  out  4: persistent status register.
- `status_clr`  in  1: synchronous clear of the status register.

## Operation
- Two register stages:
  - S1 (operand register): `a`, `b`, `op`, `set_flags`, `s1_valid`.
  - S2 (result register): `result`, `nzcv`, `set_flags`, `s2_valid`.
- Handshake signals:
  - `in_fire = in_valid && in_ready`.
  - `out_fire = out_valid && out_ready`.
  - `s1_adv = s1_valid && (!s2_valid || out_ready)`.
  - `in_ready = !s1_valid || s1_adv`. This is combinational and has no dependency on `in_valid`.
- S1 update:
  - On `in_fire`, S1 loads the inputs and `s1_valid` is set.
  - Otherwise, if `s1_adv`, `s1_valid` clears.
  - Otherwise S1 holds.
- S2 update:
  - On `s1_adv`, S2 loads `alu_out`, `alu_nzcv` and S1's `set_flags`, and `s2_valid` is set.
  - Otherwise, if `out_fire`, `s2_valid` clears.
  - Otherwise S2 holds.
- Simultaneous `out_fire` and `s1_adv` in one cycle: S2 reloads and stays valid, with no bubble.
- `alu_a`, `alu_b`, `alu_ctrl` always reflect the S1 registers, including while `s1_valid` is low.
- `out_result` and `out_nzcv` hold stable while `out_valid && !out_ready`.
- Status register:
  - On `s1_adv` with S1 `set_flags = 1`, `status_nzcv` takes `alu_nzcv` at the same edge S2 loads.
  - `status_clr` overrides this: if both occur at the same edge, the clear wins.
  - Operations with `set_flags = 0` never modify the status register.
- Implicit state machine per stage, with states EMPTY and FULL:
  - S1 goes EMPTY→FULL on `in_fire`, and FULL→EMPTY on `s1_adv && !in_fire`.
  - S2 goes EMPTY→FULL on `s1_adv`, and FULL→EMPTY on `out_fire && !s1_adv`.

## Timing
- Reset values:
  - Outputs: `in_ready = 1`, `out_valid = 0`, `out_result = 0`, `out_nzcv = 0`, `status_nzcv = 0`, `alu_a = alu_b = 0`, `alu_ctrl = 0`.
  - Internal: `s1_valid = s2_valid = 0`.
- Latency, no stall:
  - Accepted at edge E0, the result is in S2 after edge E1.
  - `out_valid` is high in the cycle following E1.
  - `status_nzcv` reflects the op after E1.
- Throughput: one op per cycle when `out_ready` is held high.
- Full stall: with `out_ready = 0`, the stage absorbs two ops, then `in_ready` drops in the same cycle S1 fills.
- Reset asserted mid-operation: both stages empty immediately and in-flight ops are discarded. The first accept is legal in the first cycle after deassertion.

## Structure
- Shared package `alu_pkg`:
  - `nzcv_t` packed struct {n, z, c, v}.
  - Flag bit index constants `NZCV_N=3`, `NZCV_Z=2`, `NZCV_C=1`, `NZCV_V=0`.
- The ALU is instantiated one level up, beside this block, and connected via the `alu_*` ports.
- One natural sub-module: `pipe_reg_stage #(W)`, a generic valid/ready register slice. It is used twice with different payload widths; the status register lives in the top.

## Test plan
- Single op, `out_ready = 1`: accept {a=8'h05, b=8'h03, set_flags=1}, with the ALU model returning out=8'h08 and nzcv=4'b0000. Required response:
  - `out_valid` high exactly 2 edges later with `out_result = 8'h08`.
  - `status_nzcv = 0000` at that time.
- Back-to-back stream of 16 ops with `out_ready = 1`: `in_ready` never drops, and results emerge in order, one per cycle.
- Hold `out_ready = 0` and offer 3 ops:
  - Only 2 are accepted and `in_ready = 0` afterwards.
  - `out_result` is stable for 10 cycles.
  - After releasing `out_ready`, all 3 results are delivered in order with no loss.
- Flags masking: op1 sets flags with nzcv=4'b0100, then op2 has `set_flags = 0` with nzcv=4'b1001. `status_nzcv` must stay 4'b0100 while `out_nzcv` shows 4'b1001.
- Clear priority: `status_clr` asserted in the same cycle as a flag-setting retire with nzcv=4'b1010 results in `status_nzcv = 0000`.
- Assert `reset` for 1 cycle while both stages are full: `out_valid` and `status_nzcv` go to 0 immediately and `in_ready = 1`; the next op completes normally.
